fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request. It generates `pc_out`/`inst_ce` and holds each request stable until memory acknowledges it. Each returned word is captured into a single-entry output buffer with a valid/ready handshake toward decode. Branch/jump redirects and an address-limit halt are handled here.

---
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues held imem requests and
// buffers one fetched word toward decode with a valid/ready handshake.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        if_ready,
  output logic [31:0] pc_out,
  output logic        inst_ce,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, REQ, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [31:0] target;
  logic [32:0] pc_inc;
  logic        accept;
  logic        consume;

  assign target  = {redirect_pc[31:2], 2'b00};
  // 33-bit sum so a wrap past 2^32 still counts as reaching the limit
  assign pc_inc  = {1'b0, pc_q} + 33'd4;
  assign inst_ce = (state_q == REQ) && (!valid_q || if_ready);
  assign accept  = inst_ce && imem_ready;
  assign consume = valid_q && if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (redirect_valid) begin
      pc_d    = target;
      valid_d = 1'b0;
      state_d = (target >= ADDR_LIMIT) ? HALT : REQ;
    end else begin
      unique case (state_q)
        IDLE: state_d = (pc_q >= ADDR_LIMIT) ? HALT : REQ;
        REQ: begin
          if (accept) begin
            inst_d  = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_inc[31:0];
            if (pc_inc >= {1'b0, ADDR_LIMIT}) state_d = HALT;
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        HALT: if (consume) valid_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out   = pc_q;
  assign if_valid = valid_q;
  assign if_inst  = inst_q;
  assign if_pc    = ipc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl against a transaction-level model.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] LIM = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_ready = 1'b0;
  logic [31:0] pc_out;
  logic        inst_ce;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        halted;

  fetch_ctrl #(.RESET_PC(RPC), .ADDR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_ready(if_ready),
    .pc_out(pc_out), .inst_ce(inst_ce), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words still held in decode's buffer: {pc, inst}
  logic [63:0] sb[$];

  // Model: fetch runs only after leaving reset, stops at the address limit,
  // and holds at most one undelivered word.
  logic [31:0] m_pc = RPC;
  bit          m_started = 0;
  bit          m_halt = 0;
  bit          m_buf = 0;

  // Monitor: whenever decode takes a word, it must be the oldest expected one
  initial forever begin
    @(negedge clk);
    #1;
    if (if_valid === 1'b1 && if_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'h1, 32'h0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("if_pc", if_pc, e[63:32]);
        chk("if_inst", if_inst, e[31:0]);
      end
    end
  end

  task automatic model_step();
    bit exp_ce;
    logic [32:0] nxt;
    exp_ce = m_started && !m_halt && (!m_buf || if_ready);
    chk("inst_ce", {31'b0, inst_ce}, {31'b0, exp_ce});
    chk("pc_out", pc_out, m_pc);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_buf});
    if (rst) begin
      m_pc = RPC; m_started = 0; m_halt = 0; m_buf = 0; sb.delete();
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_halt = (m_pc >= LIM);
      m_buf = 0; m_started = 1; sb.delete();
    end else if (!m_started) begin
      m_started = 1;
      m_halt = (m_pc >= LIM);
    end else if (exp_ce && imem_ready) begin
      sb.push_back({m_pc, imem_rdata});
      m_buf = 1;
      nxt = {1'b0, m_pc} + 33'd4;
      m_halt = (nxt >= {1'b0, LIM});
      m_pc = nxt[31:0];
    end else if (m_buf && if_ready) begin
      m_buf = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc, input bit ir, input bit ifr);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc;
    imem_ready = ir; if_ready = ifr; imem_rdata = $urandom;
    #2;
    model_step();
  endtask

  initial begin
    repeat (3) cyc(1, 0, '0, 1, 1);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);

    // Free run to the limit
    repeat (270) cyc(0, 0, '0, 1, 1);
    chk("free_halted", {31'b0, halted}, 32'h1);
    chk("free_pc", pc_out, LIM);

    // Escape from halt, run into the limit again, then redirect past it
    cyc(0, 1, 32'h20, 1, 1);
    repeat (5) cyc(0, 0, '0, 1, 1);
    cyc(0, 1, 32'h3F6, 1, 1);
    repeat (6) cyc(0, 0, '0, 1, 1);
    cyc(0, 1, 32'h400, 1, 1);
    repeat (3) cyc(0, 0, '0, 1, 1);
    chk("over_limit_pc", pc_out, 32'h400);

    // Wait states, backpressure, redirect colliding with a response
    cyc(0, 1, 32'h8, 0, 1);
    repeat (3) cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    repeat (2) cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 1);
    cyc(0, 1, 32'h102, 1, 0);
    repeat (3) cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);
    cyc(0, 0, '0, 1, 1);

    for (int i = 0; i < 4000; i++) begin
      bit r, rv;
      r  = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 39) == 0);
      cyc(r, rv, $urandom_range(0, 32'h43F), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    repeat (4) cyc(0, 0, '0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
